// File: rtl/noc_char_pkg.sv
// noc_char_pkg: shared state encoding, default widths and helpers for the NoC test sequencer
// No ports; imported by noc_phase_counter and noc_test_sequencer.
package noc_char_pkg;
  localparam int DEF_NUM_ENDPOINTS = 4;
  localparam int DEF_COUNT_WIDTH = 32;
  localparam int DEF_LAT_WIDTH = 64;
  typedef enum logic [3:0] {
    IDLE,
    EP_RESET,
    WARMUP,
    CAP_BASE,
    SCAN_BASE,
    MEASURE,
    DRAIN,
    CAP_FINAL,
    SCAN_FINAL,
    DONE
  } state_t;
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/noc_phase_counter.sv
// noc_phase_counter: loadable down-counter with zero flag used to time one test phase
// Ports: clk, rst_n (sync, active-low), i_load/i_load_val (load count),
//        i_dec (decrement, holds at zero), o_zero (count is zero).
module noc_phase_counter
  import noc_char_pkg::*;
#(
  parameter int WIDTH = DEF_COUNT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_zero
);
  logic [WIDTH-1:0] r_count;
  always_ff @(posedge clk) begin
    if (!rst_n) r_count <= '0;
    else if (i_load) r_count <= i_load_val;
    else if (i_dec && !o_zero) r_count <= r_count - WIDTH'(1);
  end
  assign o_zero = r_count == '0;
endmodule

// File: rtl/noc_test_sequencer.sv
// noc_test_sequencer: runs reset/warmup/measure/drain on NoC traffic endpoints and reports window results
// Ports: clk, rst_n (sync, active-low); i_start with phase lengths i_warmup_cycles,
//        i_measure_cycles, i_drain_timeout; o_ep_rst_n/o_gen_enable drive endpoints;
//        i_sent_count/i_recv_count/i_lat_sum/i_chk_error come back from them;
//        o_busy/o_done/o_timeout/o_error status; o_res_packets/o_res_latency/o_res_cycles results.
module noc_test_sequencer
  import noc_char_pkg::*;
#(
  parameter int NUM_ENDPOINTS = DEF_NUM_ENDPOINTS,
  parameter int COUNT_WIDTH = DEF_COUNT_WIDTH,
  parameter int LAT_WIDTH = DEF_LAT_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_start,
  input  logic [COUNT_WIDTH-1:0]   i_warmup_cycles,
  input  logic [COUNT_WIDTH-1:0]   i_measure_cycles,
  input  logic [COUNT_WIDTH-1:0]   i_drain_timeout,
  output logic                     o_ep_rst_n,
  output logic                     o_gen_enable,
  input  logic [COUNT_WIDTH-1:0]   i_sent_count [NUM_ENDPOINTS],
  input  logic [COUNT_WIDTH-1:0]   i_recv_count [NUM_ENDPOINTS],
  input  logic [LAT_WIDTH-1:0]     i_lat_sum [NUM_ENDPOINTS],
  input  logic [NUM_ENDPOINTS-1:0] i_chk_error,
  output logic                     o_busy,
  output logic                     o_done,
  output logic                     o_timeout,
  output logic                     o_error,
  output logic [COUNT_WIDTH-1:0]   o_res_packets,
  output logic [LAT_WIDTH-1:0]     o_res_latency,
  output logic [COUNT_WIDTH-1:0]   o_res_cycles
);
  localparam int IDX_W = idx_width(NUM_ENDPOINTS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ENDPOINTS - 1);

  state_t r_state, w_next, w_after_meas;
  logic [2:0] r_len_zero;
  logic r_rst_cnt, r_drained, r_timeout, r_error, r_ep_rst_n;
  logic [IDX_W-1:0] r_idx;
  logic [COUNT_WIDTH-1:0] r_sh_recv [NUM_ENDPOINTS];
  logic [LAT_WIDTH-1:0] r_sh_lat [NUM_ENDPOINTS];
  logic [COUNT_WIDTH-1:0] r_acc_pkt, r_base_pkt, r_res_pkt, r_cycles;
  logic [LAT_WIDTH-1:0] r_acc_lat, r_base_lat, r_res_lat;
  logic [COUNT_WIDTH-1:0] w_sum_sent, w_sum_recv;
  logic w_accept, w_warm_zero, w_meas_zero, w_drain_zero;
  logic w_scan, w_scan_last, w_cap, w_window, w_chk_active;

  assign w_accept = r_state == IDLE && i_start;
  assign w_scan = r_state == SCAN_BASE || r_state == SCAN_FINAL;
  assign w_scan_last = w_scan && r_idx == LAST_IDX;
  assign w_cap = r_state == CAP_BASE || r_state == CAP_FINAL;
  // The measurement window (base capture, base scan, measure) only carries
  // traffic when a non-empty measure phase was programmed.
  assign w_window = r_state == MEASURE ||
                    ((r_state == CAP_BASE || r_state == SCAN_BASE) && !r_len_zero[1]);
  assign w_chk_active = !(r_state == IDLE || r_state == EP_RESET || r_state == DONE);

  noc_phase_counter #(.WIDTH(COUNT_WIDTH)) u_warmup_cnt (
    .clk(clk), .rst_n(rst_n), .i_load(w_accept), .i_load_val(i_warmup_cycles - COUNT_WIDTH'(1)),
    .i_dec(r_state == WARMUP), .o_zero(w_warm_zero)
  );
  noc_phase_counter #(.WIDTH(COUNT_WIDTH)) u_measure_cnt (
    .clk(clk), .rst_n(rst_n), .i_load(w_accept), .i_load_val(i_measure_cycles - COUNT_WIDTH'(1)),
    .i_dec(r_state == MEASURE), .o_zero(w_meas_zero)
  );
  noc_phase_counter #(.WIDTH(COUNT_WIDTH)) u_drain_cnt (
    .clk(clk), .rst_n(rst_n), .i_load(w_accept), .i_load_val(i_drain_timeout - COUNT_WIDTH'(1)),
    .i_dec(r_state == DRAIN), .o_zero(w_drain_zero)
  );

  always_comb begin
    w_sum_sent = '0;
    w_sum_recv = '0;
    for (int e = 0; e < NUM_ENDPOINTS; e++) begin
      w_sum_sent = w_sum_sent + i_sent_count[e];
      w_sum_recv = w_sum_recv + i_recv_count[e];
    end
  end

  // Counters are loaded with length-1 at start; zero-length phases are skipped
  // using r_len_zero = {drain, measure, warmup}.
  always_comb begin
    w_next = r_state;
    w_after_meas = r_len_zero[2] ? CAP_FINAL : DRAIN;
    case (r_state)
      IDLE:       if (i_start) w_next = EP_RESET;
      EP_RESET:   if (r_rst_cnt) w_next = r_len_zero[0] ? CAP_BASE : WARMUP;
      WARMUP:     if (w_warm_zero) w_next = CAP_BASE;
      CAP_BASE:   w_next = SCAN_BASE;
      SCAN_BASE:  if (w_scan_last) w_next = r_len_zero[1] ? w_after_meas : MEASURE;
      MEASURE:    if (w_meas_zero) w_next = w_after_meas;
      DRAIN:      if (r_drained || w_drain_zero) w_next = CAP_FINAL;
      CAP_FINAL:  w_next = SCAN_FINAL;
      SCAN_FINAL: if (w_scan_last) w_next = DONE;
      default:    w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_ep_rst_n <= 1'b0;
      r_rst_cnt <= 1'b0;
      r_drained <= 1'b0;
      r_idx <= '0;
      r_len_zero <= '0;
      r_cycles <= '0;
      r_acc_pkt <= '0;
      r_acc_lat <= '0;
      r_base_pkt <= '0;
      r_base_lat <= '0;
      r_res_pkt <= '0;
      r_res_lat <= '0;
      r_timeout <= 1'b0;
      r_error <= 1'b0;
    end else begin
      r_state <= w_next;
      r_ep_rst_n <= w_next != EP_RESET;
      r_rst_cnt <= r_state == EP_RESET && !r_rst_cnt;
      // Drain compare only registers inside DRAIN, so a stale match from
      // MEASURE can never end the drain early.
      r_drained <= r_state == DRAIN && w_sum_sent == w_sum_recv;
      r_idx <= (w_scan && !w_scan_last) ? r_idx + IDX_W'(1) : '0;
      if (w_accept) begin
        r_len_zero <= {i_drain_timeout == '0, i_measure_cycles == '0, i_warmup_cycles == '0};
        r_cycles <= '0;
        r_acc_pkt <= '0;
        r_acc_lat <= '0;
        r_base_pkt <= '0;
        r_base_lat <= '0;
        r_res_pkt <= '0;
        r_res_lat <= '0;
        r_timeout <= 1'b0;
        r_error <= 1'b0;
      end else begin
        if (w_chk_active && |i_chk_error) r_error <= 1'b1;
        if (w_window && r_state != CAP_BASE) r_cycles <= r_cycles + COUNT_WIDTH'(1);
        if (r_state == DRAIN && !r_drained && w_drain_zero) r_timeout <= 1'b1;
        if (w_scan) begin
          r_acc_pkt <= r_acc_pkt + r_sh_recv[r_idx];
          r_acc_lat <= r_acc_lat + r_sh_lat[r_idx];
        end
        if (r_state == CAP_FINAL) begin
          r_base_pkt <= r_acc_pkt;
          r_base_lat <= r_acc_lat;
          r_acc_pkt <= '0;
          r_acc_lat <= '0;
        end
        // Fold the last endpoint in directly so results are valid while done pulses.
        if (r_state == SCAN_FINAL && w_scan_last) begin
          r_res_pkt <= r_acc_pkt + r_sh_recv[r_idx] - r_base_pkt;
          r_res_lat <= r_acc_lat + r_sh_lat[r_idx] - r_base_lat;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int e = 0; e < NUM_ENDPOINTS; e++) begin
      if (!rst_n) begin
        r_sh_recv[e] <= '0;
        r_sh_lat[e] <= '0;
      end else if (w_cap) begin
        r_sh_recv[e] <= i_recv_count[e];
        r_sh_lat[e] <= i_lat_sum[e];
      end
    end
  end

  assign o_ep_rst_n = r_ep_rst_n;
  assign o_gen_enable = r_state == WARMUP || w_window;
  assign o_busy = r_state != IDLE;
  assign o_done = r_state == DONE;
  assign o_timeout = r_timeout;
  assign o_error = r_error;
  assign o_res_packets = r_res_pkt;
  assign o_res_latency = r_res_lat;
  assign o_res_cycles = r_cycles;
endmodule

// File: tb/tb_noc_test_sequencer.sv
// tb_noc_test_sequencer: directed vector bench for noc_test_sequencer with loopback endpoint models
module tb_noc_test_sequencer;
  localparam int N = 4;

  typedef struct {
    logic [31:0] warm, meas, drn;
    logic [3:0]  mask;
    logic [31:0] off0;
    int          err_at;
    logic [31:0] pkts;
    logic [63:0] lat;
    logic [31:0] cyc;
    bit          chk_cyc;
    bit          to, er;
    int          post;
  } vec_t;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [31:0] warm = '0, meas = '0, drn = '0;
  logic ep_rst_n, gen_en, busy, done, timeout, error;
  logic [31:0] sent [N];
  logic [31:0] recv [N];
  logic [63:0] lat [N];
  logic [N-1:0] chk_err = '0;
  logic [31:0] res_pkts, res_cyc;
  logic [63:0] res_lat;
  logic [31:0] r_sent [N];
  logic [63:0] r_lat [N];
  logic [N-1:0] mask = '1;
  logic [31:0] off0 = '0;
  int checks = 0, failures = 0;
  vec_t vecs [5];

  always #5 clk = ~clk;

  noc_test_sequencer dut (
    .clk(clk), .rst_n(rst_n), .i_start(start),
    .i_warmup_cycles(warm), .i_measure_cycles(meas), .i_drain_timeout(drn),
    .o_ep_rst_n(ep_rst_n), .o_gen_enable(gen_en),
    .i_sent_count(sent), .i_recv_count(recv), .i_lat_sum(lat), .i_chk_error(chk_err),
    .o_busy(busy), .o_done(done), .o_timeout(timeout), .o_error(error),
    .o_res_packets(res_pkts), .o_res_latency(res_lat), .o_res_cycles(res_cyc)
  );

  // Zero-latency loopback: each generator injects one packet per enabled cycle,
  // delivering checkers see it at once and add latency e+1 per packet.
  always @(posedge clk) begin
    for (int e = 0; e < N; e++) begin
      if (!ep_rst_n) begin
        r_sent[e] <= '0;
        r_lat[e] <= '0;
      end else if (gen_en) begin
        r_sent[e] <= r_sent[e] + 32'd1;
        if (mask[e]) r_lat[e] <= r_lat[e] + 64'(e + 1);
      end
    end
  end

  always_comb begin
    for (int e = 0; e < N; e++) begin
      sent[e] = r_sent[e] + ((e == 0) ? off0 : 32'd0);
      recv[e] = mask[e] ? sent[e] : ((e == 0) ? off0 : 32'd0);
      lat[e] = r_lat[e];
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int id, input vec_t v);
    int gen_n = 0, post_n = 0, ep_low = 0, done_n = 0, tail = -1;
    logic [31:0] pk_at_done = '0;
    logic er_at_done = 1'b0;
    warm = v.warm; meas = v.meas; drn = v.drn; mask = v.mask; off0 = v.off0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk($sformatf("v%0d cleared_on_start", id), {timeout, error, res_pkts}, '0);
    for (int c = 0; c < 4000 && tail != 0; c++) begin
      if (gen_en) gen_n++;
      if (!ep_rst_n) ep_low++;
      if (busy && !gen_en && ep_rst_n && !done) post_n++;
      chk_err = (v.err_at != 0 && gen_en && gen_n == v.err_at) ? 4'b0010 : 4'b0000;
      start = (c == 8) || done;
      if (done) begin
        done_n++;
        pk_at_done = res_pkts;
        er_at_done = error;
        if (tail < 0) tail = 3;
      end
      if (tail > 0) tail--;
      @(negedge clk);
    end
    start = 1'b0;
    chk_err = '0;
    chk($sformatf("v%0d done_pulses", id), 64'(done_n), 64'd1);
    chk($sformatf("v%0d pkts_at_done", id), {32'd0, pk_at_done}, {32'd0, v.pkts});
    chk($sformatf("v%0d pkts_held", id), {32'd0, res_pkts}, {32'd0, v.pkts});
    chk($sformatf("v%0d latency", id), res_lat, v.lat);
    if (v.chk_cyc) chk($sformatf("v%0d cycles", id), {32'd0, res_cyc}, {32'd0, v.cyc});
    chk($sformatf("v%0d timeout", id), {63'd0, timeout}, {63'd0, v.to});
    chk($sformatf("v%0d error_at_done", id), {63'd0, er_at_done}, {63'd0, v.er});
    chk($sformatf("v%0d ep_rst_low_cycles", id), 64'(ep_low), 64'd2);
    chk($sformatf("v%0d post_window_cycles", id), 64'(post_n), 64'(v.post));
    chk($sformatf("v%0d idle_after_done", id), {63'd0, busy}, 64'd0);
  endtask

  initial begin
    int g;
    vecs[0] = '{warm:10, meas:100, drn:1000, mask:4'b1111, off0:0, err_at:0,
                pkts:420, lat:1050, cyc:104, chk_cyc:1, to:0, er:0, post:7};
    vecs[1] = '{warm:0, meas:0, drn:1000, mask:4'b1111, off0:0, err_at:0,
                pkts:0, lat:0, cyc:0, chk_cyc:0, to:0, er:0, post:12};
    vecs[2] = '{warm:5, meas:20, drn:50, mask:4'b1011, off0:0, err_at:0,
                pkts:75, lat:175, cyc:24, chk_cyc:1, to:1, er:0, post:55};
    vecs[3] = '{warm:3, meas:10, drn:1000, mask:4'b1111, off0:0, err_at:13,
                pkts:60, lat:150, cyc:14, chk_cyc:1, to:0, er:1, post:7};
    vecs[4] = '{warm:0, meas:3, drn:1000, mask:4'b1111, off0:32'hFFFF_FFF0, err_at:0,
                pkts:32'h20, lat:80, cyc:7, chk_cyc:1, to:0, er:0, post:7};

    repeat (3) @(negedge clk);
    chk("reset_flags", {58'd0, busy, done, gen_en, ep_rst_n, timeout, error}, 64'd0);
    chk("reset_pkts", {32'd0, res_pkts}, 64'd0);
    chk("reset_latency", res_lat, 64'd0);
    chk("reset_cycles", {32'd0, res_cyc}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_ep_rst_n", {62'd0, ep_rst_n, busy}, 64'd2);

    for (int i = 0; i < 5; i++) run_vec(i, vecs[i]);

    warm = 2; meas = 50; drn = 100; mask = '1; off0 = '0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    g = 0;
    for (int c = 0; c < 200 && g < 20; c++) begin
      @(negedge clk);
      if (gen_en) g++;
      chk_err = (gen_en && g == 1) ? 4'b0001 : 4'b0000;
    end
    chk_err = '0;
    chk("mid_reach_measure", 64'(g), 64'd20);
    chk("mid_error_before_reset", {63'd0, error}, 64'd1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_reset_flags", {58'd0, busy, done, gen_en, ep_rst_n, timeout, error}, 64'd0);
    chk("mid_reset_results", {res_lat[31:0], res_pkts}, 64'd0);
    chk("mid_reset_cycles", {32'd0, res_cyc}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    run_vec(5, vecs[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
